watch_display: RTL and testbench



---
 rtl/watch_pkg.sv | 55 +++++
 rtl/watch_display_seg7_encode.sv | 21 ++
 rtl/watch_display.sv | 146 ++++++++++++++
 tb/tb_watch_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants for the world-clock watch and its display stage.
// Glyphs are {g,f,e,d,c,b,a}; dp is added by the display stage.
package watch_pkg;

  localparam logic [6:0] G_BLANK = 7'h00;
  localparam logic [6:0] G_DASH  = 7'h40;
  localparam logic [6:0] G0 = 7'h3F;
  localparam logic [6:0] G1 = 7'h06;
  localparam logic [6:0] G2 = 7'h5B;
  localparam logic [6:0] G3 = 7'h4F;
  localparam logic [6:0] G4 = 7'h66;
  localparam logic [6:0] G5 = 7'h6D;
  localparam logic [6:0] G6 = 7'h7D;
  localparam logic [6:0] G7 = 7'h07;
  localparam logic [6:0] G8 = 7'h7F;
  localparam logic [6:0] G9 = 7'h6F;

  localparam logic [2:0] DIGIT_S0  = 3'd0;
  localparam logic [2:0] DIGIT_S1  = 3'd1;
  localparam logic [2:0] DIGIT_M0  = 3'd2;
  localparam logic [2:0] DIGIT_M1  = 3'd3;
  localparam logic [2:0] DIGIT_H0  = 3'd4;
  localparam logic [2:0] DIGIT_H1  = 3'd5;

  localparam logic [2:0] KR = 3'b110;
  localparam logic [2:0] US = 3'b101;
  localparam logic [2:0] UK = 3'b011;

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
  } snap_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] code);
    logic [6:0] g;
    g = G_BLANK;
    case (code)
      4'd0: g = G0;
      4'd1: g = G1;
      4'd2: g = G2;
      4'd3: g = G3;
      4'd4: g = G4;
      4'd5: g = G5;
      4'd6: g = G6;
      4'd7: g = G7;
      4'd8: g = G8;
      4'd9: g = G9;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/watch_display_seg7_encode.sv
// BCD code plus blank/dash override to a 7-segment glyph.
// Blank wins over dash.
module seg7_encode
  import watch_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = G_BLANK;
    unique case (1'b1)
      blank:          glyph = G_BLANK;
      dash && !blank: glyph = G_DASH;
      default:        glyph = digit_glyph(code);
    endcase
  end

endmodule

// File: rtl/watch_display.sv
// Multiplexed 6-digit 12-hour display with per-frame snapshot,
// alarm blink, PM point, country and weekday LEDs.
module watch_display
  import watch_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [5:0] hour,
  input  logic [5:0] a_min,
  input  logic [5:0] a_hour,
  input  logic       am_pm,
  input  logic       set,
  input  logic       flag,
  input  logic [2:0] nara,
  input  logic [3:0] day_cnt,
  output logic [7:0] seg,
  output logic [5:0] digit_sel,
  output logic [2:0] led_nara,
  output logic [6:0] led_day
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0] POL = {8{SEG_ACTIVE_LOW}};

  logic [PW-1:0] pre_q, pre_n;
  logic [2:0]    idx_q, idx_n;
  logic          primed_q, primed_n;
  logic          tick, take;
  snap_t         snap_q, snap_n;
  logic          set_q, flag_q;

  logic [5:0]    h12, pv;
  logic          h_bad, m_bad, s_bad, bad;
  logic [3:0]    code;
  logic          blank, dash, dp;
  logic [6:0]    glyph;
  logic [5:0]    ds_n;
  logic [2:0]    nara_n;
  logic [6:0]    day_n;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));

  // Next-slot state is computed here so seg can load with the tick.
  always_comb begin
    pre_n    = tick ? '0 : pre_q + PW'(1);
    primed_n = primed_q | tick;
    take     = tick && (!primed_q || idx_q == DIGIT_H1);
    idx_n    = idx_q;
    if (tick)
      idx_n = take ? DIGIT_S0 : idx_q + 3'd1;
    snap_n = snap_q;
    if (take) begin
      snap_n.hour = set ? a_hour : hour;
      snap_n.min  = set ? a_min : min;
      snap_n.sec  = set ? 6'd0 : sec;
      snap_n.pm   = am_pm;
    end
  end

  always_comb begin
    h_bad = snap_n.hour > 6'd23;
    m_bad = snap_n.min > 6'd59;
    s_bad = snap_n.sec > 6'd59;
    h12   = snap_n.hour;
    if (snap_n.hour == 6'd0)
      h12 = 6'd12;
    else if (snap_n.hour > 6'd12)
      h12 = snap_n.hour - 6'd12;
    pv  = snap_n.sec;
    bad = s_bad;
    unique case (1'b1)
      idx_n >= DIGIT_H0: begin
        pv  = h12;
        bad = h_bad;
      end
      idx_n >= DIGIT_M0 && idx_n < DIGIT_H0: begin
        pv  = snap_n.min;
        bad = m_bad;
      end
      default: begin
        pv  = snap_n.sec;
        bad = s_bad;
      end
    endcase
    code  = idx_n[0] ? 4'(pv / 6'd10) : 4'(pv % 6'd10);
    blank = (idx_n == DIGIT_H1 && pv < 6'd10 && !bad)
          || (set_q && !flag_q && idx_n >= DIGIT_M0);
    dash  = bad && !blank;
    dp    = (idx_n == DIGIT_S0) && snap_n.pm;
    ds_n  = '0;
    if (primed_n && pre_n >= PW'(BLANK_CYC))
      ds_n = 6'd1 << idx_n;
  end

  always_comb begin
    nara_n = '0;
    unique case (1'b1)
      nara == KR: nara_n = ~nara;
      nara == US: nara_n = ~nara;
      nara == UK: nara_n = ~nara;
      default:    nara_n = '0;
    endcase
    day_n = (day_cnt <= 4'd6) ? 7'd1 << day_cnt[2:0] : '0;
  end

  seg7_encode u_enc (
    .code  (code),
    .blank (blank),
    .dash  (dash),
    .glyph (glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      idx_q     <= '0;
      primed_q  <= 1'b0;
      snap_q    <= '0;
      set_q     <= 1'b0;
      flag_q    <= 1'b0;
      seg       <= POL;
      digit_sel <= '0;
      led_nara  <= '0;
      led_day   <= '0;
    end else begin
      pre_q     <= pre_n;
      idx_q     <= idx_n;
      primed_q  <= primed_n;
      snap_q    <= snap_n;
      set_q     <= set;
      flag_q    <= flag;
      if (tick)
        seg <= {dp, glyph} ^ POL;
      digit_sel <= ds_n;
      led_nara  <= nara_n;
      led_day   <= day_n;
    end
  end

endmodule

// File: tb/tb_watch_display.sv
// Directed bench for watch_display: scan timing, glyphs, blink,
// snapshot tearing, LEDs and mid-scan reset.
module tb_watch_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] sec = 6'd9;
  logic [5:0] min = 6'd5;
  logic [5:0] hour = 6'd13;
  logic [5:0] a_min = 6'd30;
  logic [5:0] a_hour = 6'd7;
  logic       am_pm = 1'b1;
  logic       set = 1'b0;
  logic       flag = 1'b1;
  logic [2:0] nara = 3'b110;
  logic [3:0] day_cnt = 4'd0;
  logic [7:0] seg;
  logic [5:0] digit_sel;
  logic [2:0] led_nara;
  logic [6:0] led_day;

  int checks = 0;
  int failures = 0;
  logic [7:0] shown [6];

  always #5 clk = ~clk;

  watch_display #(
    .SCAN_DIV       (8),
    .BLANK_CYC      (2),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .a_min     (a_min),
    .a_hour    (a_hour),
    .am_pm     (am_pm),
    .set       (set),
    .flag      (flag),
    .nara      (nara),
    .day_cnt   (day_cnt),
    .seg       (seg),
    .digit_sel (digit_sel),
    .led_nara  (led_nara),
    .led_day   (led_day)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ds(input logic [5:0] want);
    int n;
    n = 0;
    while (digit_sel !== want && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200)
      check("timeout", {2'b0, digit_sel}, {2'b0, want});
  endtask

  // Skip the frame in flight so the next one carries fresh inputs.
  task automatic grab_frame();
    wait_ds(6'b000001);
    wait_ds(6'b100000);
    wait_ds(6'b000001);
    for (int k = 0; k < 6; k++) begin
      wait_ds(6'd1 << k);
      shown[k] = seg;
    end
  endtask

  task automatic check_frame(input string tag,
                             input logic [7:0] e5, input logic [7:0] e4,
                             input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
    grab_frame();
    check({tag, "_d5"}, shown[5], e5);
    check({tag, "_d4"}, shown[4], e4);
    check({tag, "_d3"}, shown[3], e3);
    check({tag, "_d2"}, shown[2], e2);
    check({tag, "_d1"}, shown[1], e1);
    check({tag, "_d0"}, shown[0], e0);
  endtask

  initial begin
    logic [5:0] e;
    repeat (3) @(negedge clk);
    check("rst_ds", {2'b0, digit_sel}, 8'h00);
    check("rst_seg", seg, 8'h00);
    check("rst_nara", {5'b0, led_nara}, 8'h00);
    check("rst_day", {1'b0, led_day}, 8'h00);
    reset = 1'b0;

    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n < 8)
        e = 6'd0;
      else if ((n - 8) % 8 < 2)
        e = 6'd0;
      else
        e = 6'd1 << (((n - 8) / 8) % 6);
      check($sformatf("scan_n%0d", n), {2'b0, digit_sel}, {2'b0, e});
    end

    check_frame("h13", 8'h00, 8'h06, 8'h3F, 8'h6D, 8'h3F, 8'hEF);

    hour = 6'd0;
    am_pm = 1'b0;
    check_frame("h0", 8'h06, 8'h5B, 8'h3F, 8'h6D, 8'h3F, 8'h6F);

    hour = 6'd12;
    check_frame("h12", 8'h06, 8'h5B, 8'h3F, 8'h6D, 8'h3F, 8'h6F);

    hour = 6'd24;
    check_frame("h24", 8'h40, 8'h40, 8'h3F, 8'h6D, 8'h3F, 8'h6F);

    hour = 6'd13;
    min = 6'd60;
    check_frame("m60", 8'h00, 8'h06, 8'h40, 8'h40, 8'h3F, 8'h6F);
    min = 6'd5;

    set = 1'b1;
    flag = 1'b0;
    check_frame("blink0", 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F);

    flag = 1'b1;
    check_frame("blink1", 8'h00, 8'h07, 8'h4F, 8'h3F, 8'h3F, 8'h3F);

    set = 1'b0;
    check_frame("live", 8'h00, 8'h06, 8'h3F, 8'h6D, 8'h3F, 8'h6F);
    wait_ds(6'b000100);
    min = 6'd6;
    @(negedge clk);
    check("tear_hold", seg, 8'h6D);
    wait_ds(6'b001000);
    check("tear_d3", seg, 8'h3F);
    wait_ds(6'b000001);
    wait_ds(6'b000100);
    check("tear_new", seg, 8'h7D);

    nara = 3'b101;
    day_cnt = 4'd3;
    @(negedge clk);
    check("nara_us", {5'b0, led_nara}, 8'h02);
    check("day3", {1'b0, led_day}, 8'h08);
    nara = 3'b011;
    day_cnt = 4'd6;
    @(negedge clk);
    check("nara_uk", {5'b0, led_nara}, 8'h04);
    check("day6", {1'b0, led_day}, 8'h40);
    nara = 3'b111;
    day_cnt = 4'd7;
    @(negedge clk);
    check("nara_bad", {5'b0, led_nara}, 8'h00);
    check("day7", {1'b0, led_day}, 8'h00);
    nara = 3'b110;
    day_cnt = 4'd0;
    @(negedge clk);
    check("nara_kr", {5'b0, led_nara}, 8'h01);
    check("day0", {1'b0, led_day}, 8'h01);

    wait_ds(6'b001000);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ds", {2'b0, digit_sel}, 8'h00);
    check("mid_rst_seg", seg, 8'h00);
    check("mid_rst_led", {5'b0, led_nara}, 8'h00);
    reset = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("post_rst_n%0d", n), {2'b0, digit_sel}, 8'h00);
    end
    @(negedge clk);
    check("post_rst_first", {2'b0, digit_sel}, 8'h01);
    check("post_rst_seg", seg, 8'h6F);
    check_frame("post_rst", 8'h00, 8'h06, 8'h3F, 8'h7D, 8'h3F, 8'h6F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
